// File: rtl/ts_channel_arbiter.sv
// Four-channel timestamp arbiter feeding one shared serializer; all outputs registered.
// Round-robin by default; define TS_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest).
module ts_channel_arbiter #(
    parameter int TS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [3:0]            req,
    input  logic [4*TS_WIDTH-1:0] ts_bus,
    output logic [3:0]            ack,
    output logic                  ser_load,
    output logic [TS_WIDTH+1:0]   ser_data,
    input  logic                  ser_busy,
    output logic [1:0]            grant_ch,
    output logic                  active
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, ACK} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          ack_reg, ack_next;
    logic                ser_load_reg, ser_load_next;
    logic [TS_WIDTH+1:0] ser_data_reg, ser_data_next;
    logic [1:0]          grant_ch_reg, grant_ch_next;
    logic                active_reg, active_next;

    logic [TS_WIDTH-1:0] ts_slice [4];
    logic [3:0]          rot_req;
    logic [1:0]          start_ch;
    logic [1:0]          offset;
    logic [1:0]          winner;
    logic                grant;

`ifdef TS_ARB_FIXED_PRIO_EN
    assign start_ch = 2'd0;
`else
    // Pointer holds the last winner; it resets to 3 so the first search begins at channel 0.
    logic [1:0] last_reg, last_next;
    assign start_ch = last_reg + 2'd1;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            assign ts_slice[gi] = ts_bus[gi*TS_WIDTH +: TS_WIDTH];
            assign rot_req[gi]  = req[start_ch + 2'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated request vector is the nearest channel after the pointer.
    always_comb begin
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                offset = 2'(i);
            end
        end
    end

    assign winner = start_ch + offset;
    assign grant  = (state_reg == IDLE) && (req != 4'd0) && !ser_busy;

    always_comb begin
        state_next    = state_reg;
        ack_next      = 4'd0;
        ser_load_next = 1'b0;
        ser_data_next = ser_data_reg;
        grant_ch_next = grant_ch_reg;
`ifndef TS_ARB_FIXED_PRIO_EN
        last_next     = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    state_next    = LOAD;
                    ser_load_next = 1'b1;
                    ser_data_next = {winner, ts_slice[winner]};
                    grant_ch_next = winner;
`ifndef TS_ARB_FIXED_PRIO_EN
                    last_next     = winner;
`endif
                end
            end
            LOAD:      state_next = WAIT_BUSY;
            WAIT_BUSY: if (ser_busy) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (!ser_busy) begin
                    state_next             = ACK;
                    ack_next[grant_ch_reg] = 1'b1;
                end
            end
            ACK:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        active_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            ack_reg      <= 4'd0;
            ser_load_reg <= 1'b0;
            ser_data_reg <= '0;
            grant_ch_reg <= 2'd0;
            active_reg   <= 1'b0;
`ifndef TS_ARB_FIXED_PRIO_EN
            last_reg     <= 2'd3;
`endif
        end else begin
            state_reg    <= state_next;
            ack_reg      <= ack_next;
            ser_load_reg <= ser_load_next;
            ser_data_reg <= ser_data_next;
            grant_ch_reg <= grant_ch_next;
            active_reg   <= active_next;
`ifndef TS_ARB_FIXED_PRIO_EN
            last_reg     <= last_next;
`endif
        end
    end

    assign ack      = ack_reg;
    assign ser_load = ser_load_reg;
    assign ser_data = ser_data_reg;
    assign grant_ch = grant_ch_reg;
    assign active   = active_reg;

endmodule
